// File: rtl/fpm_pkg.sv
`default_nettype none
// ============================================================================
// Package     : fpm_pkg
// Description : Shared types and constants for the FP multiplier back end:
//               field widths, rounding-mode encoding, canonical quiet NaN
//               and the bundle carried from the normalize stage to the
//               round stage.
// Revision    : 1.0 - initial release
// ============================================================================
package fpm_pkg;

    localparam int EXP_W = 8;                      // exponent field width
    localparam int MAN_W = 23;                     // stored fraction width
    localparam int PW    = 2 * (MAN_W + 1);        // mantissa product width
    localparam int BIAS  = (1 << (EXP_W - 1)) - 1;
    localparam int FP_W  = EXP_W + MAN_W + 1;      // packed result width
    localparam int XW    = EXP_W + 4;              // internal exponent width
    localparam int LZW   = $clog2(PW + 1);         // leading-zero count width
    localparam int SHW   = $clog2(MAN_W + 4);      // denormalize shift width

    localparam logic [FP_W-1:0] QNAN =
        {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [2:0] {
        RTZ = 3'd0,
        RUP = 3'd1,
        RDN = 3'd2,
        RMM = 3'd3,
        RNE = 3'd4
    } rmode_e;

    // Normalized (or denormalized) operand waiting to be rounded.
    // exp == 0 marks a subnormal: the hidden bit is implied by the exponent.
    typedef struct packed {
        logic               sign;
        rmode_e             mode;
        logic [XW-1:0]      exp;
        logic [MAN_W-1:0]   frac;
        logic               guard;
        logic               sticky;
        logic               tiny;
        logic               nan;
        logic               inf;
        logic               zero;
    } s1_t;

    // Unused encodings fall back to round-to-nearest-even.
    function automatic rmode_e decode_mode(input logic [2:0] m);
        case (m)
            3'd0:    return RTZ;
            3'd1:    return RUP;
            3'd2:    return RDN;
            3'd3:    return RMM;
            default: return RNE;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/fpm_lzc.sv
`default_nettype none
// ============================================================================
// Module      : fpm_lzc
// Description : Parameterized leading-zero counter. o_cnt = number of zero
//               bits above the most significant one; W when i_data is zero.
// Ports       : i_data [W-1:0]  value to scan
//               o_cnt  [CW-1:0] leading-zero count
// Revision    : 1.0 - initial release
// ============================================================================
module fpm_lzc #(
    parameter int W  = 48,
    parameter int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  i_data,
    output logic [CW-1:0] o_cnt
);

    // Scanning upward lets the highest set bit have the last word.
    always_comb begin
        o_cnt = CW'(W);
        for (int i = 0; i < W; i++) begin
            if (i_data[i]) begin
                o_cnt = CW'(W - 1 - i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fpm_norm_round.sv
`default_nettype none
// ============================================================================
// Module      : fpm_norm_round
// Description : Normalize/round back end of the FP multiplier. Two-stage
//               pipeline (S1 normalize/denormalize, S2 round/pack) with
//               valid/ready on both sides; the whole pipe stalls together.
// Ports       : clk, rst (async, active-high)
//               r_mode[2:0]            rounding mode, sampled on accept
//               in_valid/in_ready      upstream handshake
//               in_sign, in_exp, in_mant, in_nan, in_inf, in_zero
//                                      raw product from the mantissa core
//               out_valid/out_ready    downstream handshake
//               fp_Z, ovrf, udrf       packed result and exception flags
// Revision    : 1.0 - initial release
// ============================================================================
module fpm_norm_round
    import fpm_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [2:0]          r_mode,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_sign,
    input  logic [EXP_W+1:0]    in_exp,
    input  logic [PW-1:0]       in_mant,
    input  logic                in_nan,
    input  logic                in_inf,
    input  logic                in_zero,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [FP_W-1:0]     fp_Z,
    output logic                ovrf,
    output logic                udrf
);

    localparam logic [FP_W-2:0] c_INF_MAG  = {{EXP_W{1'b1}}, {MAN_W{1'b0}}};
    localparam logic [FP_W-2:0] c_MAXF_MAG = {{(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
    localparam logic [XW-1:0]   c_EXP_MAX  = XW'((1 << EXP_W) - 1);

    s1_t                r_s1;
    logic               r_s1_valid;
    logic               r_out_valid;
    logic [FP_W-1:0]    r_fp_z;
    logic               r_ovrf;
    logic               r_udrf;

    logic               w_adv;
    assign w_adv    = !(r_out_valid && !out_ready);
    assign in_ready = w_adv;

    // ------------------------------------------------------------------
    // S1: normalize so the leading one sits at the top of a PW-1 bit word
    // ------------------------------------------------------------------
    logic [LZW-1:0]     w_lzc;
    logic [XW-1:0]      w_exp_in;
    logic [XW-1:0]      w_exp_nrm;
    logic [XW-1:0]      w_dexp;
    logic [PW-2:0]      w_mant_nrm;
    logic [PW-2:0]      w_mant_den;
    logic [PW-2:0]      w_mask;
    logic [SHW-1:0]     w_rsh;
    logic               w_st_nrm;
    logic               w_lost;
    logic               w_tiny;
    s1_t                w_s1;

    fpm_lzc #(.W(PW), .CW(LZW)) u_lzc (
        .i_data (in_mant),
        .o_cnt  (w_lzc)
    );

    always_comb begin
        w_exp_in = {{(XW-EXP_W-2){in_exp[EXP_W+1]}}, in_exp};

        // Product in [2,4): drop one bit into sticky and bump the exponent.
        if (w_lzc == '0) begin
            w_mant_nrm = in_mant[PW-1:1];
            w_st_nrm   = in_mant[0];
            w_exp_nrm  = w_exp_in + XW'(1);
        end else begin
            w_mant_nrm = (PW-1)'(in_mant << (w_lzc - LZW'(1)));
            w_st_nrm   = 1'b0;
            w_exp_nrm  = w_exp_in - XW'(w_lzc) + XW'(1);
        end

        // Exponent below 1: shift right into the subnormal range. Beyond
        // MAN_W+3 positions everything already lands in sticky.
        w_tiny = w_exp_nrm[XW-1] || (w_exp_nrm == '0);
        w_dexp = XW'(1) - w_exp_nrm;
        w_rsh  = (w_dexp > XW'(MAN_W + 3)) ? SHW'(MAN_W + 3) : w_dexp[SHW-1:0];
        w_mask = ((PW-1)'(1) << w_rsh) - (PW-1)'(1);
        if (w_tiny) begin
            w_mant_den = w_mant_nrm >> w_rsh;
            w_lost     = |(w_mant_nrm & w_mask);
        end else begin
            w_mant_den = w_mant_nrm;
            w_lost     = 1'b0;
        end

        w_s1.sign   = in_sign;
        w_s1.mode   = decode_mode(r_mode);
        // Hidden bit survives exactly when the value is still normal.
        w_s1.exp    = w_mant_den[PW-2] ? w_exp_nrm : '0;
        w_s1.frac   = w_mant_den[PW-3 -: MAN_W];
        w_s1.guard  = w_mant_den[PW-3-MAN_W];
        w_s1.sticky = (|w_mant_den[PW-4-MAN_W:0]) | w_lost | w_st_nrm;
        w_s1.tiny   = w_tiny;
        w_s1.nan    = in_nan;
        w_s1.inf    = in_inf;
        w_s1.zero   = in_zero || (in_mant == '0);
    end

    // ------------------------------------------------------------------
    // S2: round and pack. Adding the increment to {exp,frac} carries
    // naturally into the exponent (subnormal->normal, 1.11..1 -> 2.0).
    // ------------------------------------------------------------------
    logic                   w_inc;
    logic                   w_inexact;
    logic                   w_big;
    logic [XW+MAN_W-1:0]    w_sum;
    logic [XW-1:0]          w_sum_exp;
    logic [FP_W-1:0]        w_z;
    logic                   w_ovf;
    logic                   w_udf;

    always_comb begin
        w_inexact = r_s1.guard || r_s1.sticky;
        case (r_s1.mode)
            RTZ:     w_inc = 1'b0;
            RUP:     w_inc = !r_s1.sign && w_inexact;
            RDN:     w_inc = r_s1.sign && w_inexact;
            RMM:     w_inc = r_s1.guard;
            default: w_inc = r_s1.guard && (r_s1.sticky || r_s1.frac[0]);
        endcase

        w_sum     = {r_s1.exp, r_s1.frac} + (XW+MAN_W)'(w_inc);
        w_sum_exp = w_sum[XW+MAN_W-1:MAN_W];

        // Overflow saturates to inf only when the mode rounds away from zero
        // in the direction of the sign.
        w_big = (r_s1.mode == RNE) || (r_s1.mode == RMM) ||
                ((r_s1.mode == RUP) && !r_s1.sign) ||
                ((r_s1.mode == RDN) && r_s1.sign);

        w_ovf = 1'b0;
        w_udf = 1'b0;
        if (r_s1.nan) begin
            w_z = QNAN;
        end else if (r_s1.inf) begin
            w_z = {r_s1.sign, c_INF_MAG};
        end else if (r_s1.zero) begin
            w_z = {r_s1.sign, {(FP_W-1){1'b0}}};
        end else if (w_sum_exp >= c_EXP_MAX) begin
            w_z   = {r_s1.sign, w_big ? c_INF_MAG : c_MAXF_MAG};
            w_ovf = 1'b1;
        end else begin
            w_z   = {r_s1.sign, w_sum[EXP_W+MAN_W-1:0]};
            w_udf = r_s1.tiny && w_inexact;
        end
    end

    // ------------------------------------------------------------------
    // Pipeline registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_s1        <= '0;
            r_out_valid <= 1'b0;
            r_fp_z      <= '0;
            r_ovrf      <= 1'b0;
            r_udrf      <= 1'b0;
        end else if (w_adv) begin
            r_s1_valid  <= in_valid;
            if (in_valid) begin
                r_s1 <= w_s1;
            end
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_fp_z <= w_z;
                r_ovrf <= w_ovf;
                r_udrf <= w_udf;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign fp_Z      = r_fp_z;
    assign ovrf      = r_ovrf;
    assign udrf      = r_udrf;

endmodule
`default_nettype wire
